bcd_to_binary: RTL and testbench

Sequential decimal-to-binary converter: accepts a packed BCD number of up to ten digits and produces the equivalent 32-bit unsigned binary value, processing one digit per clock (acc = acc*10 + digit, most-significant digit first). It is the input-side counterpart of the binary-to-BCD/seven-segment display path. Decimal operands entered on board switches or a keypad are converted into register/ALU-width binary values. Valid/ready handshakes sit on both ends, and invalid-digit and overflow status flags accompany each result.

---
 rtl/bcd_to_binary_if.sv | 24 ++
 rtl/bcd_to_binary.sv | 94 +++++++++
 tb/tb_bcd_to_binary.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_if.sv
// Handshake bundle for the BCD-to-binary converter.
// The producer/consumer side uses master; the converter uses slave.
interface bcd_to_binary_if #(
  parameter int NDIGITS = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   bcd;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            bin;
  logic                   bad_digit;
  logic                   overflow;

  modport master (
    output in_valid, bcd, out_ready,
    input  in_ready, out_valid, bin, bad_digit, overflow
  );

  modport slave (
    input  in_valid, bcd, out_ready,
    output in_ready, out_valid, bin, bad_digit, overflow
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to 32-bit binary converter: one digit per clock,
// most significant digit first, with sticky invalid-digit and overflow flags.
module bcd_to_binary #(
  parameter int NDIGITS = 10
) (
  input  logic           clk,
  input  logic           rst,
  bcd_to_binary_if.slave bus
);
  localparam int              W    = 4 * NDIGITS;
  localparam int              CW   = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0]   LAST = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t        state;
  logic [W-1:0]  sr;
  logic [31:0]   acc;
  logic [CW-1:0] cnt;
  logic          bad_acc;
  logic          ovf_acc;
  logic [31:0]   bin_q;
  logic          bad_q;
  logic          ovf_q;
  logic          out_valid_q;

  logic [3:0]    d;
  logic [35:0]   nxt;

  // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
  always_comb begin
    d   = sr[W-1 -: 4];
    nxt = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + 36'(d);
  end

  // Working accumulators are separate from the presented result so that
  // bin and the flags only move on entry to DONE.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sr          <= '0;
      acc         <= '0;
      cnt         <= '0;
      bad_acc     <= 1'b0;
      ovf_acc     <= 1'b0;
      bin_q       <= '0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sr      <= bus.bcd;
            acc     <= '0;
            cnt     <= '0;
            bad_acc <= 1'b0;
            ovf_acc <= 1'b0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          acc     <= nxt[31:0];
          ovf_acc <= ovf_acc | (|nxt[35:32]);
          bad_acc <= bad_acc | (d > 4'd9);
          sr      <= sr << 4;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            bin_q       <= nxt[31:0];
            bad_q       <= bad_acc | (d > 4'd9);
            ovf_q       <= ovf_acc | (|nxt[35:32]);
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so it reads low in any cycle reset is asserted.
  assign bus.in_ready  = (state == S_IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.bin       = bin_q;
  assign bus.bad_digit = bad_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: hand-computed vector table, randomized
// words against a positional-arithmetic reference model, and handshake corner cases.
module tb_bcd_to_binary;
  localparam int ND = 10;

  typedef struct {
    logic [39:0] bcd;
    logic [31:0] bin;
    logic        bad;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] bin;
    logic        bad;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  bcd_to_binary_if #(.NDIGITS(ND)) bus ();
  bcd_to_binary #(.NDIGITS(ND)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Value = sum of digit * 10^position, evaluated in 64 bits, which is wide
  // enough for ten nibbles of up to 15 each.
  function automatic res_t ref_model(input logic [39:0] w);
    res_t            r;
    longint unsigned v;
    longint unsigned p;
    logic [3:0]      dg;
    v = 0;
    p = 1;
    r.bad = 1'b0;
    for (int i = 0; i < ND; i++) begin
      dg = w[4*i +: 4];
      v += longint'(dg) * p;
      p *= 10;
      if (dg > 4'd9) r.bad = 1'b1;
    end
    r.bin = v[31:0];
    r.ovf = (v > 64'h0000_0000_FFFF_FFFF);
    return r;
  endfunction

  // Called at a negedge with the converter idle. Offers one word, checks the
  // latency and result, optionally holds off out_ready while poking in_valid.
  task automatic run_word(input logic [39:0] word, input logic [31:0] eb, input logic ebad,
                          input logic eovf, input int hold, input string tag);
    int   lat;
    logic ir_low;
    check({tag, " idle in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.bcd       = word;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat    = 0;
    ir_low = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) ir_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(10));
    check({tag, " in_ready low in CONV"}, 64'(ir_low), 64'(1));
    check({tag, " bin"}, 64'(bus.bin), 64'(eb));
    check({tag, " flags"}, 64'({bus.bad_digit, bus.overflow}), 64'({ebad, eovf}));
    check({tag, " in_ready low in DONE"}, 64'(bus.in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.bcd      = 40'h0000000555;
      @(negedge clk);
      check({tag, " stall stable"},
            64'({bus.out_valid, bus.in_ready, bus.bad_digit, bus.overflow, bus.bin}),
            64'({1'b1, 1'b0, ebad, eovf, eb}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'(0));
    check({tag, " in_ready back"}, 64'(bus.in_ready), 64'(1));
    check({tag, " bin held"}, 64'(bus.bin), 64'(eb));
  endtask

  initial begin
    vec_t        vecs[7];
    res_t        r;
    res_t        expq[$];
    logic [39:0] w;
    logic [39:0] words[3];
    logic        seen;
    int          ndig, k, nres, cyc, last_t;

    vecs[0] = '{40'h0000000123, 32'h0000007B, 1'b0, 1'b0};
    vecs[1] = '{40'h4294967295, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2] = '{40'h4294967296, 32'h00000000, 1'b0, 1'b1};
    vecs[3] = '{40'h9999999999, 32'h540BE3FF, 1'b0, 1'b1};
    vecs[4] = '{40'h000000001A, 32'd20,       1'b1, 1'b0};
    vecs[5] = '{40'h0000000000, 32'h00000000, 1'b0, 1'b0};
    vecs[6] = '{40'hFFFFFFFFFF, 32'hE16926A9, 1'b1, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.bcd       = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(bus.in_ready), 64'(0));
    check("reset outputs",
          64'({bus.out_valid, bus.bad_digit, bus.overflow, bus.bin}), 64'(0));
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 7; i++)
      run_word(vecs[i].bcd, vecs[i].bin, vecs[i].bad, vecs[i].ovf, 0, $sformatf("vec%0d", i));

    // Backpressure with ignored in_valid pulses, then confirm nothing was taken.
    run_word(40'h0000000321, 32'd321, 1'b0, 1'b0, 5, "bp");
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
    end
    check("bp nothing accepted", 64'(seen), 64'(0));

    // Reset while idle: in_ready must read low during the reset cycle.
    rst = 1'b1;
    #1;
    check("idle reset in_ready", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Reset at the 4th CONV cycle aborts the word.
    bus.bcd      = 40'h0000000777;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort in_ready", 64'(bus.in_ready), 64'(1));
    check("abort bin", 64'(bus.bin), 64'(0));
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check("abort no result", 64'(seen), 64'(0));
    run_word(40'h0000000042, 32'd42, 1'b0, 1'b0, 0, "after abort");

    // Randomized words with random length and occasional invalid nibbles.
    for (int n = 0; n < 20; n++) begin
      w    = '0;
      ndig = $urandom_range(1, ND);
      for (int i = 0; i < ndig; i++)
        w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      r = ref_model(w);
      run_word(w, r.bin, r.bad, r.ovf, 0, $sformatf("rand%0d", n));
    end

    // Back-to-back stream with both handshakes held high.
    words[0] = 40'h0000001234;
    words[1] = 40'h0987654321;
    words[2] = 40'h5000000000;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bcd       = words[0];
    expq.push_back(ref_model(words[0]));
    k      = 1;
    nres   = 0;
    cyc    = 0;
    last_t = -1;
    while (nres < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid === 1'b1 && expq.size() > 0) begin
        r = expq.pop_front();
        check($sformatf("b2b result%0d", nres),
              64'({bus.bad_digit, bus.overflow, bus.bin}), 64'({r.bad, r.ovf, r.bin}));
        if (last_t >= 0)
          check($sformatf("b2b spacing%0d", nres), 64'(cyc - last_t), 64'(12));
        last_t = cyc;
        nres++;
      end
      if (bus.in_ready === 1'b1) begin
        if (k < 3) begin
          bus.bcd = words[k];
          expq.push_back(ref_model(words[k]));
          k++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("b2b result count", 64'(nres), 64'(3));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
